// File: rtl/syn_mc_fifo_if.sv
// Request/response bundle between producers/consumers and the multi-channel FIFO.
// Purely structural. It carries no state and adds no latency.
// Backpressure is not a handshake: producers consult full/almost_full/empty before requesting.
interface syn_mc_fifo_if #(
    parameter int DATA_WIDTH = 25,
    parameter int DEPTH      = 256,
    parameter int NUM_CH     = 4
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                       clear;
    logic                       wr_en;
    logic [CW-1:0]              wr_ch;
    logic [DATA_WIDTH-1:0]      wr_data;
    logic                       rd_en;
    logic [CW-1:0]              rd_ch;
    logic [DATA_WIDTH-1:0]      rd_data;
    logic                       rd_valid;
    logic [NUM_CH-1:0]          empty;
    logic [NUM_CH-1:0]          full;
    logic [NUM_CH-1:0]          almost_full;
    logic [NUM_CH*(AW+1)-1:0]   count;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output clear, wr_en, wr_ch, wr_data, rd_en, rd_ch,
        input  rd_data, rd_valid, empty, full, almost_full, count, overflow, underflow
    );

    modport slave (
        input  clear, wr_en, wr_ch, wr_data, rd_en, rd_ch,
        output rd_data, rd_valid, empty, full, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/syn_mc_fifo.sv
// NUM_CH independent circular queues sharing one simple-dual-port block RAM.
// Flags and counts update 1 cycle after a push. Read data and rd_valid follow 1 cycle after a pop.
// A push to a full channel or a pop from an empty one is dropped and raises a sticky error.
module syn_mc_fifo #(
    parameter int DATA_WIDTH   = 25,
    parameter int DEPTH        = 256,
    parameter int NUM_CH       = 4,
    parameter int AFULL_THRESH = DEPTH - 4
) (
    input  logic               clk,
    input  logic               rst,
    syn_mc_fifo_if.slave       bus
);
    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW        = AW + 1;
    localparam int RAM_DEPTH = NUM_CH * DEPTH;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Pointer MSB is the wrap bit; the low AW bits index within the channel's slice.
    logic [PW-1:0]          wr_ptr_q [NUM_CH];
    logic [PW-1:0]          wr_ptr_d [NUM_CH];
    logic [PW-1:0]          rd_ptr_q [NUM_CH];
    logic [PW-1:0]          rd_ptr_d [NUM_CH];

    logic [NUM_CH-1:0]      empty_w;
    logic [NUM_CH-1:0]      full_w;
    logic [NUM_CH-1:0]      afull_w;
    logic [NUM_CH*PW-1:0]   count_w;

    logic                   wr_ch_ok;
    logic                   rd_ch_ok;
    logic                   wr_acc;
    logic                   wr_rej;
    logic                   rd_acc;
    logic                   rd_rej;
    logic [CW+AW-1:0]       wr_addr;
    logic [CW+AW-1:0]       rd_addr;

    logic [DATA_WIDTH-1:0]  mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0]  rd_data_q;
    logic                   rd_valid_q;
    logic                   rd_valid_d;
    logic                   overflow_q;
    logic                   overflow_d;
    logic                   underflow_q;
    logic                   underflow_d;

    // Per-channel status derived only from registered pointers (start-of-cycle view).
    always_comb begin
        empty_w = '0;
        full_w  = '0;
        afull_w = '0;
        count_w = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            empty_w[c]            = (wr_ptr_q[c] == rd_ptr_q[c]);
            full_w[c]             = (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]) &&
                                    (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]);
            count_w[c*PW +: PW]   = wr_ptr_q[c] - rd_ptr_q[c];
            afull_w[c]            = (32'(count_w[c*PW +: PW]) >= $unsigned(AFULL_THRESH));
        end
    end

    // Accept/reject decode; out-of-range channels are silently ignored, clear overrides everything.
    always_comb begin
        wr_ch_ok = (32'(bus.wr_ch) < $unsigned(NUM_CH));
        rd_ch_ok = (32'(bus.rd_ch) < $unsigned(NUM_CH));
        wr_acc   = bus.wr_en && wr_ch_ok && !full_w[bus.wr_ch]  && !bus.clear;
        wr_rej   = bus.wr_en && wr_ch_ok &&  full_w[bus.wr_ch]  && !bus.clear;
        rd_acc   = bus.rd_en && rd_ch_ok && !empty_w[bus.rd_ch] && !bus.clear;
        rd_rej   = bus.rd_en && rd_ch_ok &&  empty_w[bus.rd_ch] && !bus.clear;
        wr_addr  = {bus.wr_ch, wr_ptr_q[bus.wr_ch][AW-1:0]};
        rd_addr  = {bus.rd_ch, rd_ptr_q[bus.rd_ch][AW-1:0]};
    end

    // Next-state for pointers, strobe and sticky errors.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_d[c] = bus.clear ? '0 : wr_ptr_q[c];
            rd_ptr_d[c] = bus.clear ? '0 : rd_ptr_q[c];
        end
        if (wr_acc) wr_ptr_d[bus.wr_ch] = wr_ptr_q[bus.wr_ch] + PTR_ONE;
        if (rd_acc) rd_ptr_d[bus.rd_ch] = rd_ptr_q[bus.rd_ch] + PTR_ONE;
        rd_valid_d  = rd_acc;
        overflow_d  = bus.clear ? 1'b0 : (overflow_q  | wr_rej);
        underflow_d = bus.clear ? 1'b0 : (underflow_q | rd_rej);
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
            end
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // RAM write port; contents are never reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_addr] <= bus.wr_data;
    end

    // RAM read port (read-first); data holds between pops, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst)         rd_data_q <= '0;
        else if (rd_acc) rd_data_q <= mem[rd_addr];
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.empty       = empty_w;
    assign bus.full        = full_w;
    assign bus.almost_full = afull_w;
    assign bus.count       = count_w;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_syn_mc_fifo.sv
// Directed bench for syn_mc_fifo: ordering, fill/overflow, underflow, wrap, concurrency, clear.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Every scenario task compares DUT outputs against hand-derived constants.
module tb_syn_mc_fifo;
    localparam int DW     = 25;
    localparam int DEPTH  = 16;
    localparam int NUM_CH = 4;
    localparam int AFT    = 12;
    localparam int AW     = 4;
    localparam int CW     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    syn_mc_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) bus ();

    syn_mc_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .AFULL_THRESH(AFT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [CW-1:0] wc, input logic [DW-1:0] wd,
                         input logic re, input logic [CW-1:0] rc, input logic clr);
        bus.wr_en   = we;
        bus.wr_ch   = wc;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.rd_ch   = rc;
        bus.clear   = clr;
    endtask

    task automatic idle;
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_clear;
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        tick;
        idle;
    endtask

    function automatic logic [AW:0] cnt(input int c);
        return bus.count[c*(AW+1) +: AW+1];
    endfunction

    task automatic test_reset;
        idle;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        n_cmp++; if (bus.empty !== 4'hF) begin n_err++; $display("FAIL reset_empty: got %h want f", bus.empty); end
        n_cmp++; if (bus.full !== 4'h0) begin n_err++; $display("FAIL reset_full: got %h want 0", bus.full); end
        n_cmp++; if (bus.almost_full !== 4'h0) begin n_err++; $display("FAIL reset_afull: got %h want 0", bus.almost_full); end
        n_cmp++; if (bus.count !== 20'h0) begin n_err++; $display("FAIL reset_count: got %h want 0", bus.count); end
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_err++; $display("FAIL reset_errs: got %b%b want 00", bus.overflow, bus.underflow); end
        n_cmp++; if (bus.rd_data !== 25'h0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
    endtask

    task automatic test_basic_order;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 2'd0, DW'(i), 1'b0, '0, 1'b0);
            tick;
        end
        n_cmp++; if (cnt(0) !== 5'd3) begin n_err++; $display("FAIL basic_count3: got %0d want 3", cnt(0)); end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, '0, '0, 1'b1, 2'd0, 1'b0);
            tick;
            n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== DW'(i)) begin
                n_err++; $display("FAIL basic_read%0d: got v=%b d=%h want v=1 d=%h", i, bus.rd_valid, bus.rd_data, DW'(i)); end
        end
        n_cmp++; if (bus.empty[0] !== 1'b1 || cnt(0) !== 5'd0) begin n_err++; $display("FAIL basic_drained: got e=%b c=%0d want e=1 c=0", bus.empty[0], cnt(0)); end
        idle;
        tick;
        n_cmp++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 25'h3) begin
            n_err++; $display("FAIL basic_hold: got v=%b d=%h want v=0 d=3", bus.rd_valid, bus.rd_data); end
    endtask

    task automatic test_fill_overflow;
        logic [AW:0] exp_c;
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 2'd2, DW'(i), 1'b0, '0, 1'b0);
            tick;
            exp_c = (i > 16) ? 5'd16 : 5'(i);
            n_cmp++; if (cnt(2) !== exp_c) begin n_err++; $display("FAIL fill_count%0d: got %0d want %0d", i, cnt(2), exp_c); end
            n_cmp++; if (bus.almost_full[2] !== (exp_c >= 5'd12)) begin n_err++; $display("FAIL fill_afull%0d: got %b want %b", i, bus.almost_full[2], exp_c >= 5'd12); end
            n_cmp++; if (bus.full[2] !== (i >= 16)) begin n_err++; $display("FAIL fill_full%0d: got %b want %b", i, bus.full[2], i >= 16); end
            n_cmp++; if (bus.overflow !== (i >= 17)) begin n_err++; $display("FAIL fill_ovf%0d: got %b want %b", i, bus.overflow, i >= 17); end
        end
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, '0, '0, 1'b1, 2'd2, 1'b0);
            tick;
            n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== DW'(i)) begin
                n_err++; $display("FAIL fill_read%0d: got v=%b d=%h want v=1 d=%h", i, bus.rd_valid, bus.rd_data, DW'(i)); end
        end
        idle;
        tick;
        n_cmp++; if (bus.empty[2] !== 1'b1 || bus.overflow !== 1'b1) begin
            n_err++; $display("FAIL fill_after: got e=%b ovf=%b want e=1 ovf=1", bus.empty[2], bus.overflow); end
        do_clear;
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL fill_ovf_clear: got %b want 0", bus.overflow); end
    endtask

    task automatic test_underflow;
        drive(1'b0, '0, '0, 1'b1, 2'd1, 1'b0);
        tick;
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL udf_valid: got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL udf_flag: got %b want 1", bus.underflow); end
        n_cmp++; if (cnt(1) !== 5'd0) begin n_err++; $display("FAIL udf_count: got %0d want 0", cnt(1)); end
        do_clear;
        n_cmp++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL udf_clear: got %b want 0", bus.underflow); end
    endtask

    task automatic test_empty_rw;
        drive(1'b1, 2'd1, 25'h77, 1'b1, 2'd1, 1'b0);
        tick;
        n_cmp++; if (bus.rd_valid !== 1'b0 || bus.underflow !== 1'b1) begin
            n_err++; $display("FAIL erw_read: got v=%b udf=%b want v=0 udf=1", bus.rd_valid, bus.underflow); end
        n_cmp++; if (cnt(1) !== 5'd1) begin n_err++; $display("FAIL erw_count: got %0d want 1", cnt(1)); end
        drive(1'b0, '0, '0, 1'b1, 2'd1, 1'b0);
        tick;
        n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 25'h77) begin
            n_err++; $display("FAIL erw_pop: got v=%b d=%h want v=1 d=77", bus.rd_valid, bus.rd_data); end
        do_clear;
    endtask

    task automatic test_full_rw;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'd2, DW'(32'h500 + i), 1'b0, '0, 1'b0);
            tick;
        end
        drive(1'b1, 2'd2, 25'h1FF, 1'b1, 2'd2, 1'b0);
        tick;
        n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 25'h500) begin
            n_err++; $display("FAIL frw_pop: got v=%b d=%h want v=1 d=500", bus.rd_valid, bus.rd_data); end
        n_cmp++; if (cnt(2) !== 5'd15 || bus.overflow !== 1'b1) begin
            n_err++; $display("FAIL frw_state: got c=%0d ovf=%b want c=15 ovf=1", cnt(2), bus.overflow); end
        do_clear;
    endtask

    task automatic test_isolation_wrap;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 2'd0, DW'(32'hA0000 + i), (i > 0), 2'd3, 1'b0);
            tick;
            if (i > 0) begin
                n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== DW'(32'hB0000 + i - 1)) begin
                    n_err++; $display("FAIL iso_b%0d: got v=%b d=%h want v=1 d=%h", i - 1, bus.rd_valid, bus.rd_data, DW'(32'hB0000 + i - 1)); end
            end
            drive(1'b1, 2'd3, DW'(32'hB0000 + i), 1'b1, 2'd0, 1'b0);
            tick;
            n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== DW'(32'hA0000 + i)) begin
                n_err++; $display("FAIL iso_a%0d: got v=%b d=%h want v=1 d=%h", i, bus.rd_valid, bus.rd_data, DW'(32'hA0000 + i)); end
        end
        drive(1'b0, '0, '0, 1'b1, 2'd3, 1'b0);
        tick;
        n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 25'hB0027) begin
            n_err++; $display("FAIL iso_b39: got v=%b d=%h want v=1 d=b0027", bus.rd_valid, bus.rd_data); end
        idle;
        n_cmp++; if (bus.count !== 20'h0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            n_err++; $display("FAIL iso_end: got c=%h o=%b u=%b want 0 0 0", bus.count, bus.overflow, bus.underflow); end
    endtask

    task automatic test_simul_rw;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'd0, DW'(32'h300 + k), 1'b0, '0, 1'b0);
            tick;
        end
        n_cmp++; if (cnt(0) !== 5'd5) begin n_err++; $display("FAIL srw_pre: got %0d want 5", cnt(0)); end
        for (int j = 0; j < 10; j++) begin
            drive(1'b1, 2'd0, DW'(32'h305 + j), 1'b1, 2'd0, 1'b0);
            tick;
            n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== DW'(32'h300 + j) || cnt(0) !== 5'd5) begin
                n_err++; $display("FAIL srw_%0d: got v=%b d=%h c=%0d want v=1 d=%h c=5", j, bus.rd_valid, bus.rd_data, cnt(0), DW'(32'h300 + j)); end
        end
        do_clear;
    endtask

    task automatic test_clear_mid;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 2'd1, DW'(32'h40 + k), 1'b0, '0, 1'b0);
            tick;
        end
        drive(1'b1, 2'd1, 25'h99, 1'b1, 2'd1, 1'b1);
        tick;
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.empty !== 4'hF || bus.count !== 20'h0) begin
            n_err++; $display("FAIL clr_state: got e=%h c=%h want e=f c=0", bus.empty, bus.count); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf: got %b want 0", bus.overflow); end
        idle;
        tick;
        n_cmp++; if (cnt(1) !== 5'd0 || bus.rd_valid !== 1'b0) begin
            n_err++; $display("FAIL clr_dropped: got c=%0d v=%b want c=0 v=0", cnt(1), bus.rd_valid); end
    endtask

    initial begin
        idle;
        test_reset;
        test_basic_order;
        test_fill_overflow;
        test_underflow;
        test_empty_rw;
        test_full_rw;
        test_isolation_wrap;
        test_simul_rw;
        test_clear_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/syn_mc_fifo.md
# syn_mc_fifo

Multi-channel BRAM-backed FIFO that partitions one simple-dual-port RAM into NUM_CH independent circular queues of DEPTH entries each. It is the parametrised successor of the single-queue accumulator FIFO: per-channel pointers, full/empty/almost-full flags, occupancy counts, sticky overflow/underflow errors and a registered read-valid strobe. It sits between the spike/accumulator producers and the neuron-update datapath, so several layers or cores can share one RAM.

## Interface

- DATA_WIDTH, 25, entry width in bits
- DEPTH, 256, entries per channel; power of two, >= 4
- NUM_CH, 4, number of logical queues; >= 1
- AFULL_THRESH, DEPTH-4, almost_full asserts when count >= this value
- Derived: AW = log2(DEPTH); CW = max(1, ceil(log2(NUM_CH))); RAM depth = NUM_CH*DEPTH

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush of all channels; RAM contents are not touched
- wr_en  in  1  write request
- wr_ch  in  CW  write channel
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- rd_ch  in  CW  read channel
- rd_data  out  DATA_WIDTH  read data, registered
- rd_valid  out  1  rd_data carries the entry popped in the previous cycle
- empty  out  NUM_CH  per-channel empty flag
- full  out  NUM_CH  per-channel full flag
- almost_full  out  NUM_CH  per-channel count >= AFULL_THRESH
- count  out  NUM_CH*(AW+1)  per-channel occupancy, 0..DEPTH; channel c in bits [c*(AW+1) +: AW+1]
- overflow  out  1  sticky: a write to a full channel was dropped
- underflow  out  1  sticky: a read from an empty channel was dropped

## Operation

- Per channel: wr_ptr and rd_ptr are AW+1 bits each. The MSB is the wrap bit. RAM address is {ch, ptr[AW-1:0]}.
- empty[c] = (wr_ptr == rd_ptr). full[c] = (low bits equal && wrap bits differ). count[c] = wr_ptr - rd_ptr, modulo 2^(AW+1).
- All flags and counts are combinational from the registered pointers, so they reflect the state at the start of the cycle.
- Write accepted = wr_en && !full[wr_ch] && !clear. When accepted: RAM[{wr_ch, wr_ptr}] <= wr_data, then wr_ptr[wr_ch]++ (natural wrap).
- Read accepted = rd_en && !empty[rd_ch] && !clear. When accepted: the RAM reads {rd_ch, rd_ptr}, then rd_ptr[rd_ch]++.
- Rejected write (wr_en && full[wr_ch] && !clear): data is discarded and overflow <= 1.
- Rejected read (rd_en && empty[rd_ch] && !clear): rd_valid stays 0 and underflow <= 1.
- wr_ch or rd_ch >= NUM_CH: the request is ignored. No pointer moves and no error flag is set.
- Simultaneous read and write, same channel:
  - Each is judged against the start-of-cycle flags.
  - On an empty channel the read is rejected; no bypass.
  - On a full channel the write is rejected.
  - Otherwise both proceed and count is unchanged.
- Simultaneous read and write on different channels are fully independent.
- clear has priority over wr_en and rd_en. It zeroes all pointers and both sticky errors, and forces rd_valid to 0 in the next cycle.
- rst has the same effect as clear. It also zeroes rd_data.
- Reset/clear state: empty = all 1s, full = 0, almost_full = 0 (given AFULL_THRESH > 0), count = 0, rd_valid = 0, overflow = 0, underflow = 0, rd_data = 0 (rst only).

## Timing

- Write-to-flag latency is 1 cycle. After an accepted write in cycle N, empty/count/full change in cycle N+1.
- Read latency is 1 cycle. For an accepted read in cycle N, rd_data and rd_valid=1 are valid in cycle N+1.
- rd_valid is a single-cycle pulse per accepted read. Back-to-back reads give consecutive valid cycles, sustaining 1 entry/cycle.
- rd_data holds its last value when rd_valid = 0.
- Write-to-read: an entry written in cycle N can be popped at the earliest in cycle N+1, with data in N+2.
- RAM read and write addresses never collide within a channel, because the empty/full gating prevents it.
- Memory is read-first, single-clock, with no output register. This implies block-RAM inference.
- A reset or clear asserted mid-stream discards an in-flight pop: rd_valid = 0 in the following cycle.

## Test plan

- **Basic ordering.** Reset, then write 0x1, 0x2, 0x3 to ch0 and read 3 times back-to-back. Expect rd_data 0x1, 0x2, 0x3 on consecutive cycles with rd_valid = 1; then empty[0] = 1 and count[0] = 0.
- **Fill and overflow.** DEPTH=16, AFULL_THRESH=12. Write 17 entries to ch2. Expect almost_full[2] from count 12, full[2] after entry 16, and overflow = 1; count[2] = 16; 16 reads return entries 1..16 in order.
- **Underflow.** Read ch1 while empty. Expect rd_valid = 0, underflow = 1, and count[1] still 0. Then clear: underflow = 0.
- **Channel isolation and wrap.** Interleave writes A0..A39 to ch0 and B0..B39 to ch3 (DEPTH=16), reading each channel as it fills so both pointers wrap twice. Both streams must come out in order, uncorrupted.
- **Simultaneous read/write, same channel.** With count[0] = 5, assert wr_en and rd_en on ch0 together for 10 cycles. Count stays 5 and the outputs are the 10 oldest entries.
- **Clear mid-operation.** Assert clear in the same cycle as accepted wr_en and rd_en on ch1. Next cycle: rd_valid = 0, all empty = 1, all count = 0, and the write is dropped without setting overflow.
